// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encodings for the bit-serial subtractor
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_fullsub.sv
// rtl/serial_subtractor_fullsub.sv - one-bit combinational full subtractor cell
module fullsub (
    input  logic A,
    input  logic B,
    input  logic bin,
    output logic diff,
    output logic bout
);

    // Difference is the parity of all three inputs; a borrow is needed when
    // B exceeds A, or when they are equal and a borrow is already pending.
    assign diff = A ^ B ^ bin;
    assign bout = (~A & B) | (~(A ^ B) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial subtractor with start/busy/done handshake
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int reglength = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [reglength-1:0] a,
    input  logic [reglength-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [reglength-1:0] diff,
    output logic                 borrow,
    output logic                 bit_out,
    output logic                 bit_valid
);

    localparam int CW = $clog2(reglength + 1);

    state_t               state;
    logic [reglength-1:0] ra;
    logic [reglength-1:0] rb;
    logic [reglength-1:0] res;
    logic [reglength-1:0] res_next;
    logic                 bin;
    logic [CW-1:0]        cnt;
    logic                 d;
    logic                 bout;
    logic                 last_bit;

    fullsub u_fullsub (
        .A    (ra[0]),
        .B    (rb[0]),
        .bin  (bin),
        .diff (d),
        .bout (bout)
    );

    // New difference bit enters at the MSB end so the first bit ends up at bit 0.
    always_comb begin
        res_next                = res >> 1;
        res_next[reglength-1]   = d;
    end

    assign last_bit = (cnt == CW'(reglength - 1));

    // Control FSM and datapath shift registers; all outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ra        <= '0;
            rb        <= '0;
            res       <= '0;
            bin       <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
            borrow    <= 1'b0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bit_valid <= 1'b0;
                    done      <= 1'b0;
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        bin   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    ra        <= ra >> 1;
                    rb        <= rb >> 1;
                    res       <= res_next;
                    bin       <= bout;
                    bit_out   <= d;
                    bit_valid <= 1'b1;
                    cnt       <= cnt + CW'(1);
                    if (last_bit) begin
                        diff   <= res_next;
                        borrow <= bout;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done      <= 1'b0;
                    bit_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    done      <= 1'b0;
                    bit_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor at widths 3, 8 and 1
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic       start3 = 1'b0, start8 = 1'b0, start1 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0, diff3;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic [0:0] a1 = '0, b1 = '0, diff1;
    logic       busy3, done3, borrow3, bit_out3, bit_valid3;
    logic       busy8, done8, borrow8, bit_out8, bit_valid8;
    logic       busy1, done1, borrow1, bit_out1, bit_valid1;

    serial_subtractor #(.reglength(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3),
        .busy(busy3), .done(done3), .diff(diff3), .borrow(borrow3),
        .bit_out(bit_out3), .bit_valid(bit_valid3)
    );

    serial_subtractor #(.reglength(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8),
        .bit_out(bit_out8), .bit_valid(bit_valid8)
    );

    serial_subtractor #(.reglength(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1),
        .bit_out(bit_out1), .bit_valid(bit_valid1)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0] q3[$];
    logic [8:0] q8[$];
    logic [8:0] q1[$];
    logic       bq3[$];
    bit         bit_chk_en = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=done required=no-done", nm);
    endtask

    // Result monitors: pop one expected {borrow, diff} per done pulse.
    always @(negedge clk) begin : mon3
        logic [8:0] e;
        if (rst_n && done3) begin
            if (q3.size() == 0) unexpected("dut3_extra_done");
            else begin
                e = q3.pop_front();
                chk("dut3_diff", {29'd0, diff3}, {29'd0, e[2:0]});
                chk("dut3_borrow", {31'd0, borrow3}, {31'd0, e[8]});
            end
        end
    end

    always @(negedge clk) begin : mon8
        logic [8:0] e;
        if (rst_n && done8) begin
            if (q8.size() == 0) unexpected("dut8_extra_done");
            else begin
                e = q8.pop_front();
                chk("dut8_diff", {24'd0, diff8}, {24'd0, e[7:0]});
                chk("dut8_borrow", {31'd0, borrow8}, {31'd0, e[8]});
            end
        end
    end

    always @(negedge clk) begin : mon1
        logic [8:0] e;
        if (rst_n && done1) begin
            if (q1.size() == 0) unexpected("dut1_extra_done");
            else begin
                e = q1.pop_front();
                chk("dut1_diff", {31'd0, diff1}, {31'd0, e[0]});
                chk("dut1_borrow", {31'd0, borrow1}, {31'd0, e[8]});
            end
        end
    end

    // Serial bit monitor for the 3-bit instance.
    always @(negedge clk) begin : monb
        logic eb;
        if (rst_n && bit_valid3 && bit_chk_en) begin
            if (bq3.size() == 0) unexpected("dut3_extra_bit");
            else begin
                eb = bq3.pop_front();
                chk("dut3_bit_out", {31'd0, bit_out3}, {31'd0, eb});
            end
        end
    end

    task automatic push3(input logic [2:0] ed, input logic eb);
        q3.push_back({eb, 5'd0, ed});
        for (int i = 0; i < 3; i++) bq3.push_back(ed[i]);
    endtask

    // One operation on the selected instance, with latency and busy-length checks.
    task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb);
        int  n_busy;
        int  n_done;
        int  n;
        logic bsy;
        logic dn;
        n_busy = 0;
        n_done = -1;
        @(negedge clk);
        case (w)
            3: begin a3 = av[2:0]; b3 = bv[2:0]; start3 = 1'b1; push3(ed[2:0], eb); end
            8: begin a8 = av; b8 = bv; start8 = 1'b1; q8.push_back({eb, ed}); end
            default: begin a1 = av[0]; b1 = bv[0]; start1 = 1'b1; q1.push_back({eb, 7'd0, ed[0]}); end
        endcase
        @(negedge clk);
        start3 = 1'b0;
        start8 = 1'b0;
        start1 = 1'b0;
        for (n = 1; n <= 40; n++) begin
            case (w)
                3: begin bsy = busy3; dn = done3; end
                8: begin bsy = busy8; dn = done8; end
                default: begin bsy = busy1; dn = done1; end
            endcase
            if (bsy) n_busy++;
            if (dn) n_done = n;
            if (!bsy) break;
            @(negedge clk);
        end
        chk($sformatf("w%0d_done_latency", w), n_done, w + 1);
        chk($sformatf("w%0d_busy_cycles", w), n_busy, w + 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t;
        int t1;
        int t2;
        int nb;

        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy3}, 0);
        chk("rst_done", {31'd0, done3}, 0);
        chk("rst_diff", {29'd0, diff3}, 0);
        chk("rst_borrow", {31'd0, borrow3}, 0);
        chk("rst_bit_valid", {31'd0, bit_valid3}, 0);
        chk("rst_bit_out", {31'd0, bit_out3}, 0);
        rst_n = 1'b1;

        run_op(3, 8'd5, 8'd3, 8'd2, 1'b0);
        run_op(3, 8'd3, 8'd5, 8'd6, 1'b1);
        run_op(3, 8'd7, 8'd7, 8'd0, 1'b0);
        run_op(3, 8'd0, 8'd7, 8'd1, 1'b1);

        // start pulsed at E2 with different operands must be dropped
        @(negedge clk);
        a3 = 3'd1; b3 = 3'd0; start3 = 1'b1;
        push3(3'd1, 1'b0);
        @(negedge clk);
        start3 = 1'b0; a3 = 3'd0; b3 = 3'd7;
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done3) break;
            @(negedge clk);
        end
        @(negedge clk);
        nb = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy3) nb++;
        end
        chk("ignored_start_busy", nb, 0);
        chk("ignored_start_queue", q3.size(), 0);

        // start held high: back-to-back operations
        @(negedge clk);
        a3 = 3'd4; b3 = 3'd1; start3 = 1'b1;
        push3(3'd3, 1'b0);
        push3(3'd7, 1'b1);
        @(negedge clk);
        a3 = 3'd2; b3 = 3'd3;
        t1 = -1;
        t2 = -1;
        for (t = 1; t <= 40; t++) begin
            if (done3) begin
                if (t1 < 0) t1 = t;
                else begin
                    t2 = t;
                    start3 = 1'b0;
                    break;
                end
            end
            @(negedge clk);
        end
        start3 = 1'b0;
        chk("held_start_gap", t2 - t1, 5);
        repeat (2) @(negedge clk);

        // asynchronous reset mid-RUN
        bit_chk_en = 1'b0;
        a3 = 3'd5; b3 = 3'd2; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy3}, 0);
        chk("arst_done", {31'd0, done3}, 0);
        chk("arst_diff", {29'd0, diff3}, 0);
        chk("arst_borrow", {31'd0, borrow3}, 0);
        chk("arst_bit_valid", {31'd0, bit_valid3}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bit_chk_en = 1'b1;
        run_op(3, 8'd6, 8'd1, 8'd5, 1'b0);

        run_op(8, 8'h00, 8'h01, 8'hFF, 1'b1);
        run_op(8, 8'hA5, 8'h5A, 8'h4B, 1'b0);

        run_op(1, 8'd0, 8'd1, 8'd1, 1'b1);
        run_op(1, 8'd1, 8'd0, 8'd1, 1'b0);
        run_op(1, 8'd1, 8'd1, 8'd0, 1'b0);

        repeat (3) @(negedge clk);
        chk("q3_drained", q3.size(), 0);
        chk("q8_drained", q8.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("bq3_drained", bq3.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor computing diff = a - b, LSB first, one bit per clock, using a one-bit full-subtractor cell.
- Inverse-operation counterpart to the team's bit-serial adder datapath; same operand width parameter and LSB-first shift order.
- Adds a start/busy/done handshake, an explicit FSM and a parallel result register so it can sit behind a controller.

Parameters:
- reglength, 3, operand and result width in bits; legal range 1 and up.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  reglength  minuend; captured on the accepting edge.
- b  input  reglength  subtrahend; captured on the accepting edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; diff and borrow are final while high.
- diff  output  reglength  result modulo 2^reglength, two's complement.
- borrow  output  1  final borrow out; 1 means a < b unsigned.
- bit_out  output  1  difference bit produced on the last edge.
- bit_valid  output  1  high for one cycle after each RUN edge.

Behaviour:
- Reset (rst_n low, any time, including mid-RUN): state IDLE; counter, shift registers, diff, borrow, bit_out, bit_valid, done and busy all 0. The operation in progress is discarded. The first accepting edge after release is the earliest edge on which start is honoured.
- FSM states:
  - IDLE: busy=0. If start=1 at edge E0: latch a into ra and b into rb, clear the borrow flop, clear the counter, go to RUN. Otherwise stay in IDLE.
  - RUN: at each edge compute d = ra[0] ^ rb[0] ^ bin and bout = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & bin).
    - Shift ra and rb right by 1.
    - Shift d into the result register from the MSB end, right-shifting, so after reglength edges bit 0 is the LSB.
    - Set bin to bout, bit_out to d, bit_valid to 1, and increment the counter.
    - On the edge where the counter reaches reglength-1, i.e. edge E_reglength: load diff from the completed result and borrow from bout, then go to DONE.
  - DONE: done=1 for exactly one cycle, bit_valid=0. Next edge goes to IDLE.
- Latency:
  - done is high in the cycle following edge E_reglength, i.e. reglength+1 edges after the accepting edge.
  - Throughput is one operation per reglength+2 cycles.
- start behaviour:
  - start while busy=1 is ignored; it is not queued.
  - start held high continuously gives back-to-back operations with one IDLE cycle between them.
- diff and borrow hold their values from DONE until the next DONE or reset. They are not cleared on start.
- The a and b inputs are don't-care except on the accepting edge.
- Boundaries:
  - a == b gives diff 0, borrow 0.
  - a=0, b=max gives diff 1, borrow 1.
  - reglength=1 takes one RUN edge.
- Counter width is $clog2(reglength+1). All internal arithmetic is 1-bit; there is no wide adder.

Decomposition:
- Shared include file: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
- Sub-module fullsub, purely combinational.
  - Inputs: A, B, bin.
  - Outputs: diff, bout.
  - Counterpart of the team's one-bit full adder; instantiated once on ra[0], rb[0] and the borrow flop.

Test Plan:
- reglength=3, a=5, b=3, start pulse at E0 -> bit_out sequence 0,1,0 at E1..E3; done high after E3; diff=3'b010, borrow=0; busy high for 4 cycles.
- reglength=3, a=3, b=5 -> diff=3'b110, borrow=1; a=7, b=7 -> diff=0, borrow=0.
- reglength=8, a=8'h00, b=8'h01 -> diff=8'hFF, borrow=1, done 9 edges after accept; a=8'hA5, b=8'h5A -> diff=8'h4B, borrow=0.
- Pulse start again at E2 of an operation with different a and b -> ignored; result matches the first operands. start held high -> second done exactly reglength+2 cycles after the first.
- Drop rst_n asynchronously mid-RUN (between edges) -> busy, done, diff, borrow, bit_valid go to 0 immediately. After release, a new start with a=6, b=1 -> diff=3'b101, borrow=0.
- reglength=1: a=0, b=1 -> diff=1, borrow=1, done one cycle after the single RUN edge.
